// File: rtl/hazard_ctrl.sv
// Operand-select encoding shared between the hazard controller and the EX operand muxes.
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        id2ex_buf   = 2'd0,   // operand from the ID/EX pipeline buffer
        mem_forward = 2'd1,   // operand forwarded from the EX/MEM result
        wb_forward  = 2'd2    // operand forwarded from the MEM/WB result
    } alu_data_sel_t;
endpackage

// Purpose: RV32I 5-stage hazard control -- registered EX forwarding selects, load-use stall, redirect flush.
// Latency: selects registered, valid while the consumer sits in EX (1 cycle after ID); stall/flush are combinational.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and bubbles ID/EX; a redirect flushes IF/ID and bubbles ID/EX.
//
// Ports:
//   clk, rst                      core clock, async active-high reset
//   id_*_i                        decoded fields of the instruction in ID
//   ex_redirect_i                 taken branch / jump resolved in EX
//   alu_rs1/rs2_data_sel_c_o      EX operand mux selects
//   stall_pc_o, stall_if_id_o     hold front end
//   flush_if_id_o, bubble_id_ex_o squash IF/ID, insert NOP into ID/EX
//   stall_cnt_o, flush_cnt_o      saturating event counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_is_load_i,
    input  logic                  ex_redirect_i,
    output alu_data_sel_t         alu_rs1_data_sel_c_o,
    output alu_data_sel_t         alu_rs2_data_sel_c_o,
    output logic                  stall_pc_o,
    output logic                  stall_if_id_o,
    output logic                  flush_if_id_o,
    output logic                  bubble_id_ex_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  ld;
    } slot_t;

    slot_t ex_slot, mem_slot, wb_slot;
    slot_t id_info;

    alu_data_sel_t rs1_sel_q, rs2_sel_q;
    alu_data_sel_t rs1_sel_d, rs2_sel_d;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic load_use;
    logic bubble;
    logic id_advance;

    // x0 is hardwired zero, so a write to it is never a real producer.
    function automatic logic slot_match(input slot_t s,
                                        input logic [REG_ADDR_W-1:0] rs,
                                        input logic used);
        return s.valid && s.we && (s.rd == rs) && (rs != '0) && used;
    endfunction

    // Younger producer (EX) wins; its result will sit in EX/MEM next cycle.
    function automatic alu_data_sel_t pick_sel(input slot_t ex_s,
                                               input slot_t mem_s,
                                               input logic [REG_ADDR_W-1:0] rs,
                                               input logic used);
        if (slot_match(ex_s, rs, used)) begin
            return mem_forward;
        end else if (slot_match(mem_s, rs, used)) begin
            return wb_forward;
        end
        return id2ex_buf;
    endfunction

    always_comb begin
        id_info       = '0;
        id_info.valid = id_valid_i;
        id_info.rd    = id_rd_addr_i;
        id_info.we    = id_reg_write_i;
        id_info.ld    = id_is_load_i;
    end

    always_comb begin
        load_use = id_valid_i && ex_slot.ld &&
                   (slot_match(ex_slot, id_rs1_addr_i, id_rs1_used_i) ||
                    slot_match(ex_slot, id_rs2_addr_i, id_rs2_used_i));
    end

    // Redirect overrides load-use: the stalled consumer is being squashed anyway,
    // so the front end must move on to the new PC rather than hold.
    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        bubble_id_ex_o = 1'b0;
        if (ex_redirect_i) begin
            flush_if_id_o  = 1'b1;
            bubble_id_ex_o = 1'b1;
        end else if (load_use) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            bubble_id_ex_o = 1'b1;
        end
    end

    assign bubble     = bubble_id_ex_o;
    assign id_advance = id_valid_i && !bubble;

    always_comb begin
        rs1_sel_d = id2ex_buf;
        rs2_sel_d = id2ex_buf;
        if (id_advance) begin
            rs1_sel_d = pick_sel(ex_slot, mem_slot, id_rs1_addr_i, id_rs1_used_i);
            rs2_sel_d = pick_sel(ex_slot, mem_slot, id_rs2_addr_i, id_rs2_used_i);
        end
    end

    // WB slot is tracked for completeness; the register file bypasses WB writes
    // to same-cycle ID reads, so it never produces a forward select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= id_advance ? id_info : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_sel_q <= id2ex_buf;
            rs2_sel_q <= id2ex_buf;
        end else begin
            rs1_sel_q <= rs1_sel_d;
            rs2_sel_q <= rs2_sel_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_use && !ex_redirect_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ex_redirect_i && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign alu_rs1_data_sel_c_o = rs1_sel_q;
    assign alu_rs2_data_sel_c_o = rs2_sel_q;
    assign stall_cnt_o          = stall_cnt_q;
    assign flush_cnt_o          = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction-sequence steps, expected selects queued
// when an instruction is presented in ID and checked once it occupies EX.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_u1 = 1'b0, id_u2 = 1'b0, id_we = 1'b0, id_ld = 1'b0;
    logic          redirect = 1'b0;
    alu_data_sel_t sel1, sel2;
    logic          stall_pc, stall_if_id, flush_if_id, bubble_id_ex;
    logic [31:0]   stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    alu_data_sel_t exp1_q[$];
    alu_data_sel_t exp2_q[$];

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .id_valid_i           (id_valid),
        .id_rs1_addr_i        (id_rs1),
        .id_rs2_addr_i        (id_rs2),
        .id_rs1_used_i        (id_u1),
        .id_rs2_used_i        (id_u2),
        .id_rd_addr_i         (id_rd),
        .id_reg_write_i       (id_we),
        .id_is_load_i         (id_ld),
        .ex_redirect_i        (redirect),
        .alu_rs1_data_sel_c_o (sel1),
        .alu_rs2_data_sel_c_o (sel2),
        .stall_pc_o           (stall_pc),
        .stall_if_id_o        (stall_if_id),
        .flush_if_id_o        (flush_if_id),
        .bubble_id_ex_o       (bubble_id_ex),
        .stall_cnt_o          (stall_cnt),
        .flush_cnt_o          (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive at negedge, check comb hazard outputs, queue the selects
    // the instruction should see in EX, then compare them after the clock edge.
    task automatic step(input string tag,
                        input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld,
                        input logic redir, input logic e_stall, input logic e_flush,
                        input alu_data_sel_t e1, input alu_data_sel_t e2);
        alu_data_sel_t p1, p2;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_u1 = u1; id_rs2 = rs2; id_u2 = u2;
        id_rd = rd; id_we = we; id_ld = ld; redirect = redir;
        #1;
        chk({tag, ".stall_pc"},    32'(stall_pc),     32'(e_stall));
        chk({tag, ".stall_if_id"}, 32'(stall_if_id),  32'(e_stall));
        chk({tag, ".flush"},       32'(flush_if_id),  32'(e_flush));
        chk({tag, ".bubble"},      32'(bubble_id_ex), 32'(e_stall | e_flush));
        exp1_q.push_back(e1);
        exp2_q.push_back(e2);
        @(posedge clk);
        #1;
        p1 = exp1_q.pop_front();
        p2 = exp2_q.pop_front();
        chk({tag, ".sel1"}, 32'(sel1), 32'(p1));
        chk({tag, ".sel2"}, 32'(sel2), 32'(p2));
    endtask

    task automatic nop(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, id2ex_buf, id2ex_buf);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.sel1", 32'(sel1), 32'(id2ex_buf));
        chk("rst.sel2", 32'(sel2), 32'(id2ex_buf));
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        chk("rst.flush_cnt", flush_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nop("idle", 1);

        // add x5,x1,x2 ; sub x6,x5,x3 -> rs1 from EX/MEM
        step("add", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, id2ex_buf, id2ex_buf);
        step("sub", 1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0, 0, mem_forward, id2ex_buf);
        // lui x8 names x6 in its rs1 field but does not read it
        step("lui", 1, 5'd6, 0, 5'd6, 0, 5'd8, 1, 0, 0, 0, 0, id2ex_buf, id2ex_buf);
        nop("drain1", 3);

        // add x5 ; nop ; or x7,x0,x5 -> rs2 from MEM/WB
        step("add2", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, id2ex_buf, id2ex_buf);
        nop("gap", 1);
        step("or",   1, 5'd0, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0, 0, id2ex_buf, wb_forward);
        nop("drain2", 3);

        // lw x0 ; add x6,x0,x0 -> x0 never hazards
        step("lwx0",  1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, id2ex_buf, id2ex_buf);
        step("addx0", 1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0, 0, id2ex_buf, id2ex_buf);
        nop("drain3", 3);

        // lw x5 ; add x6,x5,x5 with redirect in the same cycle
        step("lwr",  1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, id2ex_buf, id2ex_buf);
        step("redir", 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 1, 0, 1, id2ex_buf, id2ex_buf);
        chk("redir.flush_cnt", flush_cnt, 32'd1);
        chk("redir.stall_cnt", stall_cnt, 32'd0);
        nop("drain4", 3);

        // lw x5 ; add x6,x5,x5 -> one stall cycle, then forward from MEM/WB
        step("lw",    1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, id2ex_buf, id2ex_buf);
        step("lu1",   1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 1, 0, id2ex_buf, id2ex_buf);
        step("lu2",   1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, wb_forward, wb_forward);
        chk("lu.stall_cnt", stall_cnt, 32'd1);
        chk("lu.flush_cnt", flush_cnt, 32'd1);
        nop("drain5", 3);

        // Saturation of the flush counter
        force dut.flush_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.flush_cnt_q;
        step("sat", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1, id2ex_buf, id2ex_buf);
        chk("sat.flush_cnt", flush_cnt, 32'hFFFF_FFFF);
        step("sat2", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1, id2ex_buf, id2ex_buf);
        chk("sat2.flush_cnt", flush_cnt, 32'hFFFF_FFFF);
        nop("drain6", 3);

        // Reset asserted in the middle of a load-use stall
        step("lwm", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, id2ex_buf, id2ex_buf);
        @(negedge clk);
        id_valid = 1; id_rs1 = 5'd5; id_u1 = 1; id_rs2 = 5'd5; id_u2 = 1;
        id_rd = 5'd6; id_we = 1; id_ld = 0; redirect = 0;
        #1;
        chk("mid.stall_pc", 32'(stall_pc), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid.rst.stall_pc",    32'(stall_pc),     32'd0);
        chk("mid.rst.stall_if_id", 32'(stall_if_id),  32'd0);
        chk("mid.rst.bubble",      32'(bubble_id_ex), 32'd0);
        chk("mid.rst.flush",       32'(flush_if_id),  32'd0);
        chk("mid.rst.sel1",        32'(sel1),         32'(id2ex_buf));
        chk("mid.rst.sel2",        32'(sel2),         32'(id2ex_buf));
        chk("mid.rst.stall_cnt",   stall_cnt,         32'd0);
        chk("mid.rst.flush_cnt",   flush_cnt,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        id_valid = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
